// File: rtl/fitness_arbiter.sv
// Round-robin arbiter sharing one fitness evaluator between several requesters.
// Queues start pulses, issues one evaluation at a time, and returns finish/error to the winner.
module fitness_arbiter #(
  parameter int unsigned NumRequesters   = 4,
  parameter int unsigned IndividualWidth = 64,
  parameter int unsigned ErrorWidth      = 5,
  parameter int unsigned TimeoutCycles   = 1024,
  parameter int unsigned IdWidth         = $clog2(NumRequesters)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NumRequesters-1:0]                   reqStart,
  input  logic [NumRequesters*IndividualWidth-1:0]   reqIndividual,
  output logic [NumRequesters-1:0]                   reqFinish,
  output logic [ErrorWidth-1:0]                      reqError,
  output logic [IndividualWidth-1:0]                 fitIndividual,
  output logic                                       fitStart,
  input  logic                                       fitFinish,
  input  logic [ErrorWidth-1:0]                      fitError,
  output logic [IdWidth-1:0]                         grantId,
  output logic                                       busy,
  output logic                                       timeout
);

  // Counter only needs to reach TimeoutCycles-2; the abort fires on the following WAIT edge.
  localparam int unsigned CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NumRequesters-1:0]     r_pending;
  logic [NumRequesters-1:0]     w_pend_eff;
  logic [NumRequesters-1:0]     w_clear;
  logic [IdWidth-1:0]           r_rr_ptr;
  logic [IdWidth-1:0]           r_grant_id;
  logic [IdWidth-1:0]           w_winner;
  logic [IdWidth-1:0]           w_scan_idx;
  logic                         w_found;
  logic [CntWidth-1:0]          r_cnt;
  logic [CntWidth-1:0]          w_cnt_nxt;
  logic                         w_timeout_c;
  logic [IndividualWidth-1:0]   r_fit_ind;
  logic                         r_fit_start;
  logic [NumRequesters-1:0]     r_req_finish;
  logic [ErrorWidth-1:0]        r_req_error;
  logic                         r_busy;
  logic                         r_timeout;
  logic [IndividualWidth-1:0]   w_slices [NumRequesters];

  for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_slice
    assign w_slices[gi] = reqIndividual[gi*IndividualWidth +: IndividualWidth];
  end

  // A same-cycle pulse is visible to arbitration so an idle arbiter grants on the next edge.
  assign w_pend_eff = r_pending | reqStart;

  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int unsigned k = 0; k < NumRequesters; k++) begin
      w_scan_idx = IdWidth'((32'(r_rr_ptr) + k) % NumRequesters);
      if (!w_found && w_pend_eff[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_clear = '0;
    if (r_state == S_DONE) begin
      w_clear[r_grant_id] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_timeout_c = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (fitFinish) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == CntWidth'(TimeoutCycles - 2)) begin
          w_timeout_c = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CntWidth'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pending    <= '0;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_fit_ind    <= '0;
      r_fit_start  <= 1'b0;
      r_req_finish <= '0;
      r_req_error  <= '0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fit_start <= (w_state_nxt == S_ISSUE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_timeout   <= w_timeout_c;
      // Set beats clear so a re-pulse during DONE queues a fresh evaluation.
      r_pending   <= (r_pending & ~w_clear) | reqStart;

      r_req_finish <= '0;
      if (w_state_nxt == S_DONE) begin
        r_req_finish[r_grant_id] <= 1'b1;
      end

      if (r_state == S_IDLE && w_found) begin
        r_grant_id <= w_winner;
        r_fit_ind  <= w_slices[w_winner];
      end

      if (r_state == S_WAIT) begin
        if (fitFinish) begin
          r_req_error <= fitError;
        end else if (w_timeout_c) begin
          r_req_error <= '1;
        end
      end

      if (r_state == S_DONE) begin
        r_rr_ptr <= (r_grant_id == IdWidth'(NumRequesters - 1)) ? '0 : r_grant_id + IdWidth'(1);
      end
    end
  end

  assign reqFinish     = r_req_finish;
  assign reqError      = r_req_error;
  assign fitIndividual = r_fit_ind;
  assign fitStart      = r_fit_start;
  assign grantId       = r_grant_id;
  assign busy          = r_busy;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_fitness_arbiter.sv
// Directed self-checking bench for fitness_arbiter with a short watchdog (8 cycles).
module tb_fitness_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IW  = 64;
  localparam int unsigned EW  = 5;
  localparam int unsigned TO  = 8;
  localparam int unsigned IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      reqStart;
  logic [N*IW-1:0]   reqIndividual;
  logic [N-1:0]      reqFinish;
  logic [EW-1:0]     reqError;
  logic [IW-1:0]     fitIndividual;
  logic              fitStart;
  logic              fitFinish;
  logic [EW-1:0]     fitError;
  logic [IDW-1:0]    grantId;
  logic              busy;
  logic              timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int fin_cnt [N] = '{0, 0, 0, 0};

  fitness_arbiter #(
    .NumRequesters  (N),
    .IndividualWidth(IW),
    .ErrorWidth     (EW),
    .TimeoutCycles  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reqStart     (reqStart),
    .reqIndividual(reqIndividual),
    .reqFinish    (reqFinish),
    .reqError     (reqError),
    .fitIndividual(fitIndividual),
    .fitStart     (fitStart),
    .fitFinish    (fitFinish),
    .fitError     (fitError),
    .grantId      (grantId),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (reqFinish[i] === 1'b1) fin_cnt[i] = fin_cnt[i] + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; reqStart = '0; fitFinish = 1'b0; fitError = '0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic wait_fit_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (fitStart === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // Answers one evaluation after lat WAIT cycles; returns what was seen in the DONE cycle.
  task automatic run_eval(input int lat, input logic [EW-1:0] err, input logic [N-1:0] done_mask,
                          output int gid, output logic [N-1:0] fin, output logic [EW-1:0] rerr);
    bit ok;
    wait_fit_start(ok);
    gid = ok ? int'(grantId) : -1;
    repeat (lat) tick;
    fitFinish = 1'b1; fitError = err;
    tick;
    fitFinish = 1'b0;
    fin  = reqFinish;
    rerr = reqError;
    reqStart = done_mask;
    tick;
    reqStart = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; reqStart = '0; fitFinish = 1'b0; fitError = '0;
    tick; tick;
    n_checks++; if ({fitIndividual, reqError, grantId, reqFinish, fitStart, busy, timeout} !== '0)
      $display("FAIL reset_outputs: got %0h required 0", {fitIndividual, reqError, grantId, reqFinish, fitStart, busy, timeout}); else n_pass++;
    rst = 1'b0;
    fitFinish = 1'b1; fitError = 5'd9;
    tick;
    fitFinish = 1'b0;
    tick;
    n_checks++; if (busy !== 1'b0 || reqFinish !== 4'b0000 || reqError !== 5'd0)
      $display("FAIL reset_idle_stray_finish: busy=%0b fin=%b err=%0h required 0/0000/0", busy, reqFinish, reqError); else n_pass++;
  endtask

  task automatic test_single;
    apply_reset;
    reqStart = 4'b0001;
    tick;
    reqStart = '0;
    n_checks++; if (fitStart !== 1'b1) $display("FAIL single_fitstart: got %0b required 1", fitStart); else n_pass++;
    n_checks++; if (fitIndividual !== 64'hA5) $display("FAIL single_individual: got %0h required a5", fitIndividual); else n_pass++;
    n_checks++; if (grantId !== 2'd0 || busy !== 1'b1) $display("FAIL single_grant: id=%0d busy=%0b required 0/1", grantId, busy); else n_pass++;
    tick;
    n_checks++; if (fitStart !== 1'b0) $display("FAIL single_fitstart_pulse: got %0b required 0", fitStart); else n_pass++;
    tick; tick;
    fitFinish = 1'b1; fitError = 5'd7;
    tick;
    fitFinish = 1'b0;
    n_checks++; if (reqFinish !== 4'b0001) $display("FAIL single_finish: got %b required 0001", reqFinish); else n_pass++;
    n_checks++; if (reqError !== 5'd7) $display("FAIL single_error: got %0d required 7", reqError); else n_pass++;
    tick;
    n_checks++; if (reqFinish !== 4'b0000 || busy !== 1'b0 || reqError !== 5'd7)
      $display("FAIL single_after: fin=%b busy=%0b err=%0d required 0000/0/7", reqFinish, busy, reqError); else n_pass++;
  endtask

  task automatic test_simultaneous;
    int gid; logic [N-1:0] fin; logic [EW-1:0] rerr;
    apply_reset;
    reqStart = 4'b1111;
    tick;
    reqStart = '0;
    for (int k = 0; k < 4; k++) begin
      run_eval(1 + k, EW'(k + 10), 4'b0000, gid, fin, rerr);
      n_checks++; if (gid !== k) $display("FAIL simul_order_%0d: got %0d required %0d", k, gid, k); else n_pass++;
      n_checks++; if (fin !== 4'(1 << k) || rerr !== EW'(k + 10))
        $display("FAIL simul_finish_%0d: fin=%b err=%0d required %b/%0d", k, fin, rerr, 4'(1 << k), k + 10); else n_pass++;
    end
    // Pointer must have wrapped back to 0: requester 0 beats requester 3.
    reqStart = 4'b1001;
    tick;
    reqStart = '0;
    run_eval(1, 5'd1, 4'b0000, gid, fin, rerr);
    n_checks++; if (gid !== 0) $display("FAIL simul_wrap_first: got %0d required 0", gid); else n_pass++;
    run_eval(1, 5'd2, 4'b0000, gid, fin, rerr);
    n_checks++; if (gid !== 3 || fin !== 4'b1000) $display("FAIL simul_wrap_second: id=%0d fin=%b required 3/1000", gid, fin); else n_pass++;
  endtask

  task automatic test_fairness;
    int gid; int starts; logic [N-1:0] fin; logic [EW-1:0] rerr;
    logic [N-1:0] masks [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0000};
    int exp_id [4] = '{1, 2, 1, 2};
    apply_reset;
    reqStart = 4'b0110;
    tick;
    reqStart = '0;
    for (int k = 0; k < 4; k++) begin
      run_eval(2, 5'd4, masks[k], gid, fin, rerr);
      n_checks++; if (gid !== exp_id[k] || fin !== 4'(1 << exp_id[k]))
        $display("FAIL fair_order_%0d: id=%0d fin=%b required %0d", k, gid, fin, exp_id[k]); else n_pass++;
    end
    starts = 0;
    repeat (8) begin
      if (fitStart !== 1'b0 || busy !== 1'b0) starts++;
      tick;
    end
    n_checks++; if (starts !== 0) $display("FAIL fair_idle_after: got %0d active cycles required 0", starts); else n_pass++;
  endtask

  task automatic test_duplicate;
    int gid; int starts; int f3; bit ok; logic [N-1:0] fin; logic [EW-1:0] rerr;
    apply_reset;
    f3 = fin_cnt[3];
    reqStart = 4'b0001;
    tick;
    reqStart = '0;
    wait_fit_start(ok);
    n_checks++; if (!ok || grantId !== 2'd0) $display("FAIL dup_first_grant: ok=%0b id=%0d required 1/0", ok, grantId); else n_pass++;
    tick;
    reqStart = 4'b1000; tick; reqStart = '0; tick;
    reqStart = 4'b1000; tick; reqStart = '0;
    fitFinish = 1'b1; fitError = 5'd2;
    tick;
    fitFinish = 1'b0;
    n_checks++; if (reqFinish !== 4'b0001) $display("FAIL dup_first_finish: got %b required 0001", reqFinish); else n_pass++;
    tick;
    run_eval(2, 5'd5, 4'b0000, gid, fin, rerr);
    n_checks++; if (gid !== 3 || fin !== 4'b1000 || rerr !== 5'd5)
      $display("FAIL dup_second_eval: id=%0d fin=%b err=%0d required 3/1000/5", gid, fin, rerr); else n_pass++;
    starts = 0;
    repeat (10) begin
      if (fitStart !== 1'b0) starts++;
      tick;
    end
    n_checks++; if (starts !== 0) $display("FAIL dup_no_extra_start: got %0d required 0", starts); else n_pass++;
    n_checks++; if (fin_cnt[3] - f3 !== 1) $display("FAIL dup_finish_count: got %0d required 1", fin_cnt[3] - f3); else n_pass++;
  endtask

  task automatic test_timeout;
    int n; bit ok;
    apply_reset;
    reqStart = 4'b0110;
    tick;
    reqStart = '0;
    wait_fit_start(ok);
    n_checks++; if (!ok || grantId !== 2'd1) $display("FAIL to_grant: ok=%0b id=%0d required 1/1", ok, grantId); else n_pass++;
    n = 0;
    while (timeout !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    n_checks++; if (n !== 8) $display("FAIL to_latency: got %0d cycles required 8", n); else n_pass++;
    n_checks++; if (reqFinish !== 4'b0010 || reqError !== 5'h1F)
      $display("FAIL to_finish: fin=%b err=%0h required 0010/1f", reqFinish, reqError); else n_pass++;
    tick;
    n_checks++; if (timeout !== 1'b0 || reqFinish !== 4'b0000)
      $display("FAIL to_pulse: timeout=%0b fin=%b required 0/0000", timeout, reqFinish); else n_pass++;
    wait_fit_start(ok);
    n_checks++; if (!ok || grantId !== 2'd2) $display("FAIL to_next_grant: ok=%0b id=%0d required 1/2", ok, grantId); else n_pass++;
    // Finish arrives on the very cycle the watchdog would expire: finish must win.
    repeat (7) tick;
    fitFinish = 1'b1; fitError = 5'd3;
    tick;
    fitFinish = 1'b0;
    n_checks++; if (timeout !== 1'b0 || reqFinish !== 4'b0100 || reqError !== 5'd3)
      $display("FAIL to_finish_wins: timeout=%0b fin=%b err=%0d required 0/0100/3", timeout, reqFinish, reqError); else n_pass++;
    tick;
  endtask

  task automatic test_async_reset;
    int bad; bit ok;
    apply_reset;
    reqStart = 4'b0100;
    tick;
    reqStart = '0;
    wait_fit_start(ok);
    tick; tick;
    n_checks++; if (!ok || grantId !== 2'd2 || fitIndividual !== 64'h2222_2222_2222_2222 || busy !== 1'b1)
      $display("FAIL ar_pre: id=%0d ind=%0h busy=%0b required 2/2222222222222222/1", grantId, fitIndividual, busy); else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || grantId !== 2'd0 || fitIndividual !== 64'h0 || fitStart !== 1'b0 || reqFinish !== 4'b0000)
      $display("FAIL ar_immediate: busy=%0b id=%0d ind=%0h required all 0", busy, grantId, fitIndividual); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fitFinish = 1'b1; fitError = 5'd9;
    bad = 0;
    repeat (10) begin
      tick;
      fitFinish = 1'b0;
      if (reqFinish !== 4'b0000 || fitStart !== 1'b0 || busy !== 1'b0 || reqError !== 5'd0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL ar_after_release: got %0d active cycles required 0", bad); else n_pass++;
  endtask

  initial begin
    reqIndividual = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                     64'h1111_1111_1111_1111, 64'h0000_0000_0000_00A5};
    test_reset;
    test_single;
    test_simultaneous;
    test_fairness;
    test_duplicate;
    test_timeout;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/fitness_arbiter.md
Name: fitness_arbiter

Overview:
- Shares one MorphologicFitness evaluator between several EttoreAG-style requesters (e.g. parallel GA islands).
- Queues start pulses and grants the evaluator round-robin.
- Drives the evaluator's start/individual inputs, captures its error on finish, and routes a finish pulse plus error back to the granted requester.
- A watchdog aborts evaluations that never finish.

Parameters:
- NumRequesters, 4, number of requesters (>=2)
- IndividualWidth, 64, width of one individual
- ErrorWidth, 5, width of fitness error
- TimeoutCycles, 1024, max cycles in WAIT before abort (>=2)
- IdWidth, $clog2(NumRequesters), width of grant index

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- reqStart  input  NumRequesters  one-cycle start pulse per requester
- reqIndividual  input  NumRequesters*IndividualWidth  packed individuals; requester i uses slice i
- reqFinish  output  NumRequesters  one-cycle done pulse per requester
- reqError  output  ErrorWidth  error of last completed evaluation; valid with reqFinish
- fitIndividual  output  IndividualWidth  individual presented to evaluator
- fitStart  output  1  one-cycle start pulse to evaluator
- fitFinish  input  1  evaluator done pulse
- fitError  input  ErrorWidth  evaluator result, valid with fitFinish
- grantId  output  IdWidth  requester currently owning evaluator
- busy  output  1  high in ISSUE/WAIT/DONE
- timeout  output  1  one-cycle pulse when watchdog aborts

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pending=0; rrPtr=0; all outputs 0 (fitIndividual, reqError, grantId, reqFinish, fitStart, busy, timeout).
  - Reset mid-evaluation drops all pending and in-flight work; a later fitFinish is ignored.
- pending[i] is set on the rising clk where reqStart[i]=1. A reqStart[i] while pending[i] is already 1 is ignored: no double queue, no extra finish.
- IDLE:
  - If pending!=0, pick the first set bit scanning rrPtr, rrPtr+1, ... mod NumRequesters.
  - Register grantId=winner and fitIndividual=slice winner; go to ISSUE.
  - A request pulsed in cycle t is granted at the earliest edge t+1 if the arbiter is idle.
- ISSUE: fitStart=1 for exactly this cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - fitIndividual and grantId held constant.
  - On fitFinish=1: reqError<=fitError; go to DONE.
  - Otherwise the counter increments. When it reaches TimeoutCycles-1 without fitFinish: reqError<=all ones, timeout=1 for one cycle, go to DONE.
- DONE:
  - reqFinish[grantId]=1 for exactly this cycle; clear pending[grantId]; rrPtr<=grantId+1 (wrap to 0 past NumRequesters-1); go to IDLE.
  - If reqStart[grantId] is 1 in this same cycle, the set wins: pending stays 1 and a new evaluation is queued.
- fitFinish outside WAIT is ignored.
- fitFinish and timeout on the same cycle: fitFinish wins, timeout stays 0.
- reqError holds its value until the next completion.
- Requester contract: hold its reqIndividual slice stable from reqStart until its reqFinish. The arbiter samples it only at grant.
- Minimum turnaround per evaluation: IDLE+ISSUE+WAIT(>=1)+DONE = 4 cycles. No overlap of evaluations.
- busy = (state != IDLE).

Test Plan:
- Single request:
  - Stimulus: reqStart=0001, individual0=64'hA5; evaluator answers fitFinish with fitError=7 three cycles after fitStart.
  - Required: fitStart one cycle after grant; fitIndividual=64'hA5; reqFinish=0001 one pulse; reqError=7; busy falls afterwards.
- Simultaneous requests:
  - Stimulus: reqStart=1111 in one cycle, rrPtr=0.
  - Required: grants in order 0,1,2,3; four reqFinish pulses, one per bit; rrPtr ends at 0.
- Fairness:
  - Stimulus: requester 1 re-pulses during DONE of every evaluation while requester 2 is pending.
  - Required: grant order 1,2,1,2; requester 2 is never starved.
- Duplicate pulse:
  - Stimulus: reqStart[3] pulsed twice before its grant.
  - Required: exactly one evaluation and one reqFinish[3].
- Timeout:
  - Stimulus: TimeoutCycles=8, evaluator never finishes.
  - Required: timeout pulses 8 cycles after fitStart; reqError=5'h1F; reqFinish pulses; the next pending request is granted.
- Async reset in WAIT:
  - Stimulus: rst asserted mid-cycle during WAIT, then a stray fitFinish after release.
  - Required: outputs go to 0 immediately; no reqFinish; pending=0; state IDLE.
